// File: rtl/car_request_latch_pkg.sv
// Shared traffic-controller encodings: sensor indices, lane-pair masks and 48 MHz timing defaults.
package traffic_pkg;

  typedef enum logic [1:0] {
    CAR1 = 2'd0,
    CAR2 = 2'd1,
    CAR3 = 2'd2,
    CAR4 = 2'd3
  } car_idx_e;

  localparam logic [3:0] PAIR13 = 4'b0101;
  localparam logic [3:0] PAIR24 = 4'b1010;

  localparam int unsigned DEBOUNCE_CYCLES_48M = 48000;
  localparam int unsigned MAX_WAIT_48M        = 480000000;

endpackage

// File: rtl/car_request_latch_if.sv
// Sensor/request bundle between the pins-side conditioning stage and the light controller.
interface car_request_latch_if;
  logic [3:0] car_raw;
  logic       served13;
  logic       served24;
  logic [3:0] car_clean;
  logic       req13;
  logic       req24;
  logic       urgent13;
  logic       urgent24;

  modport master (
    output car_raw, served13, served24,
    input  car_clean, req13, req24, urgent13, urgent24
  );

  modport slave (
    input  car_raw, served13, served24,
    output car_clean, req13, req24, urgent13, urgent24
  );
endinterface

// File: rtl/car_request_latch_debounce.sv
// One sensor channel: two-flop synchroniser, debounce counter, clean level and rising-edge pulse.
module car_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_48M
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise
);
  localparam logic [DEBOUNCE_W-1:0] LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            sync_ff;
  logic [DEBOUNCE_W-1:0] count;
  logic                  clean_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      count   <= '0;
      clean   <= 1'b0;
      clean_d <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      clean_d <= clean;
      // Any return to the accepted level restarts the hold count.
      if (sync_ff[1] == clean) begin
        count <= '0;
      end else if (count == LAST) begin
        clean <= sync_ff[1];
        count <= '0;
      end else begin
        count <= count + DEBOUNCE_W'(1);
      end
    end
  end

  assign rise = clean & ~clean_d;

endmodule

// File: rtl/car_request_latch.sv
// Four-sensor conditioning and sticky per-pair service requests for the traffic light controller.
// Optional per-pair wait timers and urgent flags are built when CAR_WAIT_TIMER_EN is defined.
module car_request_latch
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_48M,
  parameter int unsigned WAIT_W          = 32,
  parameter int unsigned MAX_WAIT        = MAX_WAIT_48M
) (
  input  logic sclk,
  input  logic rst,
  car_request_latch_if.slave bus
);
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (64'd1 << DEBOUNCE_W))
    $error("DEBOUNCE_CYCLES out of range for DEBOUNCE_W");
  if (WAIT_W < 32 && longint'(MAX_WAIT) >= (64'd1 << WAIT_W))
    $error("MAX_WAIT unreachable by a WAIT_W-bit timer");

  logic [3:0] clean;
  logic [3:0] rise;
  logic       req13;
  logic       req24;
  logic       set13;
  logic       set24;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    car_debounce #(
      .DEBOUNCE_W     (DEBOUNCE_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (sclk),
      .rst  (rst),
      .raw  (bus.car_raw[i]),
      .clean(clean[i]),
      .rise (rise[i])
    );
  end

  assign set13 = |(rise & PAIR13);
  assign set24 = |(rise & PAIR24);

  // Set wins over serve so a car arriving during green is still queued.
  always_ff @(posedge sclk) begin
    if (rst) begin
      req13 <= 1'b0;
      req24 <= 1'b0;
    end else begin
      req13 <= set13 | (req13 & ~bus.served13);
      req24 <= set24 | (req24 & ~bus.served24);
    end
  end

  assign bus.car_clean = clean;
  assign bus.req13     = req13;
  assign bus.req24     = req24;

`ifdef CAR_WAIT_TIMER_EN
  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] timer13;
  logic [WAIT_W-1:0] timer24;
  logic              urgent13;
  logic              urgent24;

  always_ff @(posedge sclk) begin
    if (rst) begin
      timer13  <= '0;
      timer24  <= '0;
      urgent13 <= 1'b0;
      urgent24 <= 1'b0;
    end else begin
      if (!req13 || bus.served13) timer13 <= '0;
      else if (timer13 != '1)     timer13 <= timer13 + WAIT_W'(1);
      if (!req24 || bus.served24) timer24 <= '0;
      else if (timer24 != '1)     timer24 <= timer24 + WAIT_W'(1);
      urgent13 <= (timer13 >= MAX_WAIT_V);
      urgent24 <= (timer24 >= MAX_WAIT_V);
    end
  end

  assign bus.urgent13 = urgent13;
  assign bus.urgent24 = urgent24;
`else
  assign bus.urgent13 = 1'b0;
  assign bus.urgent24 = 1'b0;
`endif

endmodule

// File: tb/tb_car_request_latch.sv
// Directed bench for car_request_latch: expectations are queued per cycle and checked by a monitor.
module tb_car_request_latch;
  logic sclk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   c;
  int   r;
  int   passed = 0;
  int   total  = 0;

  // Observed vector layout: {urgent24, urgent13, req24, req13, car_clean[3:0]}
  typedef struct {
    int         cyc;
    logic [7:0] mask;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  logic [7:0] obs;

  car_request_latch_if bus ();

  car_request_latch #(
    .DEBOUNCE_W     (16),
    .DEBOUNCE_CYCLES(8),
    .WAIT_W         (32),
    .MAX_WAIT       (20)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  assign obs = {bus.urgent24, bus.urgent13, bus.req24, bus.req13, bus.car_clean};

  function automatic void expect_at(int at, logic [7:0] mask, logic [7:0] v, string name);
    exp_t e;
    int i;
    e.cyc  = at;
    e.mask = mask;
    e.exp  = v;
    e.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > at) i--;
    sb.insert(i, e);
  endfunction

  task automatic run(int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  always @(negedge sclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_mon = sb.pop_front();
      total++;
      if (e_mon.cyc != cyc)
        $display("FAIL %s: check for cycle %0d reached late at cycle %0d", e_mon.name, e_mon.cyc, cyc);
      else if ((obs & e_mon.mask) !== (e_mon.exp & e_mon.mask))
        $display("FAIL %s @cyc %0d: got %02h, required %02h (mask %02h)",
                 e_mon.name, cyc, obs & e_mon.mask, e_mon.exp & e_mon.mask, e_mon.mask);
      else
        passed++;
    end
  end

  initial begin
    rst              = 1'b1;
    bus.car_raw      = 4'hF;
    bus.served13     = 1'b0;
    bus.served24     = 1'b0;

    // Reset held three edges with all sensors active, then the first free cycle.
    for (int i = 1; i <= 4; i++) expect_at(i, 8'hFF, 8'h00, "reset");
    run(3);
    rst         = 1'b0;
    bus.car_raw = 4'h0;
    run(6);

    // Clean arrival on car1.
    c = cyc;
    bus.car_raw[0] = 1'b1;
    expect_at(c + 9,  8'h3F, 8'h00, "arrive_pre");
    expect_at(c + 10, 8'h3F, 8'h01, "arrive_clean");
    expect_at(c + 11, 8'h3F, 8'h11, "arrive_req");
    run(12);

    // Glitchy car4 never qualifies.
    c = cyc;
    for (int i = 1; i <= 22; i++) expect_at(c + i, 8'h39, 8'h11, "glitch");
    bus.car_raw[3] = 1'b1; run(5);
    bus.car_raw[3] = 1'b0; run(2);
    bus.car_raw[3] = 1'b1; run(5);
    bus.car_raw[3] = 1'b0; run(11);

    // car3 rise coincides with served13; set must win.
    c = cyc;
    bus.car_raw[2] = 1'b1;
    expect_at(c + 10, 8'h3F, 8'h15, "collide_pre");
    expect_at(c + 11, 8'h3F, 8'h15, "collide_hold");
    expect_at(c + 13, 8'h3F, 8'h15, "collide_still");
    expect_at(c + 14, 8'h3F, 8'h05, "collide_clear");
    expect_at(c + 20, 8'h3F, 8'h05, "persist13");
    run(10);
    bus.served13 = 1'b1; run(1);
    bus.served13 = 1'b0; run(2);
    bus.served13 = 1'b1; run(1);
    bus.served13 = 1'b0; run(6);
    bus.car_raw  = 4'h0;
    run(14);

    // Persistent car2 across a serve, then a genuine re-arrival.
    c = cyc;
    bus.car_raw[1] = 1'b1;
    expect_at(c + 11, 8'h3F, 8'h22, "persist_req");
    expect_at(c + 12, 8'h3F, 8'h22, "persist_pre");
    expect_at(c + 13, 8'h3F, 8'h02, "persist_clear");
    expect_at(c + 30, 8'h3F, 8'h02, "persist_norereq");
    expect_at(c + 42, 8'h3F, 8'h00, "persist_release");
    expect_at(c + 52, 8'h3F, 8'h02, "rearrive_clean");
    expect_at(c + 53, 8'h3F, 8'h22, "rearrive_req");
    run(12);
    bus.served24 = 1'b1; run(1);
    bus.served24 = 1'b0; run(17);
    bus.car_raw[1] = 1'b0; run(12);
    bus.car_raw[1] = 1'b1; run(11);

    // Wait timer on pair 2&4; req24 rose at edge r.
    r = c + 53;
`ifdef CAR_WAIT_TIMER_EN
    expect_at(r + 20, 8'h80, 8'h00, "urgent_early");
    expect_at(r + 21, 8'hA0, 8'hA0, "urgent_set");
    expect_at(r + 25, 8'hA0, 8'hA0, "urgent_hold");
    expect_at(r + 26, 8'h20, 8'h00, "urgent_req_clear");
    expect_at(r + 27, 8'hA0, 8'h00, "urgent_clear");
`else
    expect_at(r + 21, 8'hA0, 8'h20, "urgent_off");
    expect_at(r + 25, 8'hC0, 8'h00, "urgent_off_hold");
    expect_at(r + 27, 8'hA0, 8'h00, "urgent_off_clear");
`endif
    run(25);
    bus.served24 = 1'b1; run(1);
    bus.served24 = 1'b0; run(6);

    while (sb.size() > 0) begin
      e_mon = sb.pop_front();
      total++;
      $display("FAIL %s: cycle %0d never checked", e_mon.name, e_mon.cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
